// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register for the 5-stage MIPS core.
// Holds the fetch PC, addresses instruction memory and resolves the next PC from D-stage control.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       pc_op,
  input  logic             beq_equal,
  input  logic [31:0]      rs_val_d,
  input  logic [31:0]      instr_f,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [5:0]       opcode_d,
  output logic [5:0]       funct_d,
  output logic [31:0]      pc4_d,
  output logic [31:0]      pc8_d,
  output logic             addr_err
);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'd0,
    OP_BEQ    = 3'd1,
    OP_JUMP   = 3'd2,
    OP_JR     = 3'd3,
    OP_BGEZAL = 3'd4
  } pc_op_e;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_addr_err;

  logic [31:0] w_pc4_f;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_jr_tgt;
  logic        w_jr_misalign;
  logic [31:0] w_im_off;
  logic [31:0] w_npc;

  assign w_pc4_f       = r_pc + 32'd4;
  assign w_br_off      = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_tgt      = r_pc4 + w_br_off;
  assign w_j_tgt       = {r_pc4[31:28], r_instr[25:0], 2'b00};
  assign w_jr_tgt      = {rs_val_d[31:2], 2'b00};
  assign w_jr_misalign = (rs_val_d[1:0] != 2'b00);

  // Offset from the IM base; high bits are dropped, so out-of-range PCs alias.
  assign w_im_off = r_pc - PC_RESET;
  assign im_addr  = IM_AW'(w_im_off >> 2);

  always_comb begin
    w_npc = w_pc4_f;
    case (pc_op_e'(pc_op))
      OP_BEQ:    w_npc = beq_equal ? w_br_tgt : w_pc4_f;
      OP_JUMP:   w_npc = w_j_tgt;
      OP_JR:     w_npc = w_jr_tgt;
      OP_BGEZAL: w_npc = w_br_tgt;
      default:   w_npc = w_pc4_f;
    endcase
  end

  // Stall freezes everything; the redirect is recomputed once the stall lifts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc       <= PC_RESET;
      r_instr    <= 32'd0;
      r_pc4      <= PC_RESET;
      r_addr_err <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_npc;
      r_instr <= instr_f;
      r_pc4   <= w_pc4_f;
      if (pc_op == OP_JR && w_jr_misalign)
        r_addr_err <= 1'b1;
    end
  end

  assign pc_f     = r_pc;
  assign instr_d  = r_instr;
  assign opcode_d = r_instr[31:26];
  assign funct_d  = r_instr[5:0];
  assign pc4_d    = r_pc4;
  assign pc8_d    = r_pc4 + 32'd4;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural IM, per-edge expected state queued and compared after each edge.
module tb_fetch_stage;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam int          IM_AW    = 10;

  logic             clk = 1'b0;
  logic             reset, stall, beq_equal;
  logic [2:0]       pc_op;
  logic [31:0]      rs_val_d, instr_f;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      pc_f, instr_d, pc4_d, pc8_d;
  logic [5:0]       opcode_d, funct_d;
  logic             addr_err;

  logic [31:0] mem [0:(1<<IM_AW)-1];
  assign instr_f = mem[im_addr];

  fetch_stage #(.PC_RESET(PC_RESET), .IM_AW(IM_AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .beq_equal(beq_equal),
    .rs_val_d(rs_val_d), .instr_f(instr_f), .im_addr(im_addr), .pc_f(pc_f),
    .instr_d(instr_d), .opcode_d(opcode_d), .funct_d(funct_d), .pc4_d(pc4_d),
    .pc8_d(pc8_d), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [31:0]      pc4;
    logic             err;
    logic [IM_AW-1:0] ia;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IM_AW-1:0] ia_of(input logic [31:0] pc);
    logic [31:0] off;
    off = (pc - PC_RESET) >> 2;
    return off[IM_AW-1:0];
  endfunction

  // One clock: drive at negedge, predict the post-edge state, compare #1 after the edge.
  task automatic step(input logic rst_n, input logic stl, input logic [2:0] op,
                      input logic beq, input logic [31:0] rs);
    exp_t e;
    logic [31:0] npc, brt, imm_ext;
    @(negedge clk);
    reset = rst_n; stall = stl; pc_op = op; beq_equal = beq; rs_val_d = rs;
    if (!rst_n) begin
      m_pc = PC_RESET; m_instr = 32'd0; m_pc4 = PC_RESET; m_err = 1'b0;
    end else if (!stl) begin
      imm_ext = {{16{m_instr[15]}}, m_instr[15:0]};
      brt = m_pc4 + (imm_ext << 2);
      case (op)
        3'd1:    npc = beq ? brt : m_pc + 32'd4;
        3'd2:    npc = {m_pc4[31:28], m_instr[25:0], 2'b00};
        3'd3:    npc = rs & 32'hFFFF_FFFC;
        3'd4:    npc = brt;
        default: npc = m_pc + 32'd4;
      endcase
      if (op == 3'd3 && rs[1:0] != 2'b00) m_err = 1'b1;
      m_instr = mem[ia_of(m_pc)];
      m_pc4   = m_pc + 32'd4;
      m_pc    = npc;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.err = m_err; e.ia = ia_of(m_pc);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("pc_f", pc_f, e.pc);
      chk("instr_d", instr_d, e.instr);
      chk("pc4_d", pc4_d, e.pc4);
      chk("pc8_d", pc8_d, e.pc4 + 32'd4);
      chk("opcode_d", {26'd0, opcode_d}, {26'd0, e.instr[31:26]});
      chk("funct_d", {26'd0, funct_d}, {26'd0, e.instr[5:0]});
      chk("addr_err", {31'd0, addr_err}, {31'd0, e.err});
      chk("im_addr", {{(32-IM_AW){1'b0}}, im_addr}, {{(32-IM_AW){1'b0}}, e.ia});
    end
  endtask

  task automatic run0(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << IM_AW); i++) mem[i] = $urandom;
    mem[0] = 32'h2001_0001;
    mem[1] = {6'h03, 26'h000_0C10};
    mem[4] = {6'h04, 5'd1, 5'd2, 16'hFFFC};
    reset = 1'b1; stall = 1'b0; pc_op = 3'd0; beq_equal = 1'b0; rs_val_d = 32'd0;

    // reset and sequential fetch
    step(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    chk("rst_pc", pc_f, 32'h0000_3000);
    chk("rst_instr", instr_d, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    run0(1);
    chk("seq_pc1", pc_f, 32'h0000_3004);
    chk("seq_lag", instr_d, mem[0]);
    run0(1);
    chk("seq_pc2", pc_f, 32'h0000_3008);
    chk("jal_pc8", pc8_d, 32'h0000_300C);
    // jal in D with pc4_d = 3008
    step(1'b1, 1'b0, 3'd2, 1'b0, 32'd0);
    chk("jal_tgt", pc_f, 32'h0000_3040);

    // beq taken at 3010
    step(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    run0(5);
    chk("beq_in_d", instr_d, mem[4]);
    chk("beq_pc_slot", pc_f, 32'h0000_3014);
    step(1'b1, 1'b0, 3'd1, 1'b1, 32'd0);
    chk("beq_taken", pc_f, 32'h0000_3004);
    chk("beq_slot_d", instr_d, mem[5]);
    // beq not taken
    step(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    run0(5);
    step(1'b1, 1'b0, 3'd1, 1'b0, 32'd0);
    chk("beq_not", pc_f, 32'h0000_3018);

    // misaligned jr, sticky error, cleared by reset
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'h0000_3022);
    chk("jr_pc", pc_f, 32'h0000_3020);
    chk("jr_err", {31'd0, addr_err}, 32'd1);
    run0(2);
    chk("jr_sticky", {31'd0, addr_err}, 32'd1);
    step(1'b0, 1'b0, 3'd0, 1'b0, 32'd0);
    chk("err_clr", {31'd0, addr_err}, 32'd0);
    chk("err_clr_pc", pc_f, 32'h0000_3000);

    // stall with jr in D, rs forwarded late
    run0(1);
    step(1'b1, 1'b1, 3'd3, 1'b0, 32'd0);
    step(1'b1, 1'b1, 3'd3, 1'b0, 32'd0);
    chk("stall_pc", pc_f, 32'h0000_3004);
    chk("stall_instr", instr_d, mem[0]);
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'h0000_3100);
    chk("unstall_jr", pc_f, 32'h0000_3100);

    // reset wins over stall
    step(1'b0, 1'b1, 3'd2, 1'b0, 32'd0);
    chk("rst_stall_pc", pc_f, 32'h0000_3000);
    chk("rst_stall_instr", instr_d, 32'd0);

    // PC wrap and im_addr aliasing
    run0(1);
    step(1'b1, 1'b0, 3'd3, 1'b0, 32'hFFFF_FFFC);
    run0(1);
    chk("wrap_pc", pc_f, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rs;
      rs = $urandom;
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), 1'($urandom), rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
